// File: rtl/ice_bridge.sv
// ice_bridge: UART byte-stream debug bridge onto the ICE bus.
// Decodes nibble-oriented command bytes and runs bus reads and writes with an
// ACK/timeout handshake. Status and data bytes go back over a valid/ready TX
// stream, and the bridge also drives the core run-control outputs.
module ice_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              ICE_BUS_REQ,
    output logic              ICE_BUS_WE,
    output logic [ADDR_W-1:0] ICE_BUS_ADDR,
    output logic [DATA_W-1:0] ICE_BUS_WDATA,
    input  logic [DATA_W-1:0] ICE_BUS_RDATA,
    input  logic              ICE_BUS_ACK,
    output logic              ICE_CORE_RESET,
    output logic [1:0]        ICE_CORE_STATE,
    output logic              ICE_BUSY
);

    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam int NNIB = DATA_W / 4;

    // Last cycle index of REQ: REQ stays high for exactly TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [7:0] ST_OK      = 8'hA0;
    localparam logic [7:0] ST_TIMEOUT = 8'hE0;
    localparam logic [7:0] ST_BADCMD  = 8'hEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP,
        S_DUMP
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] snap_q;   // dump snapshot, next nibble kept in the top bits
    logic [3:0]        rem_q;    // dump bytes still to send after the one on TX
    logic [CW-1:0]     cnt_q;
    logic              req_q;
    logic              we_q;
    logic              inc_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              rx_ready_q;
    logic              busy_q;
    logic              core_rst_q;
    logic [1:0]        core_state_q;

    logic [3:0]        rx_cmd;
    logic [3:0]        rx_n;
    logic [ADDR_W-1:0] addr_shift_d;
    logic [DATA_W-1:0] data_shift_d;
    logic [DATA_W-1:0] snap_shift_d;
    logic [ADDR_W-1:0] addr_inc_d;

    assign rx_cmd = RX_DATA[7:4];
    assign rx_n   = RX_DATA[3:0];

    // Nibble shift-in paths and the address increment used after a bus ACK.
    always_comb begin
        addr_shift_d = (addr_q << 4) | ADDR_W'(rx_n);
        data_shift_d = (data_q << 4) | DATA_W'(rx_n);
        snap_shift_d = snap_q << 4;
        addr_inc_d   = addr_q + ADDR_W'(1);
    end

    // Command FSM; every output below is driven straight from a register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            snap_q       <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            inc_q        <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            rx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            core_rst_q   <= 1'b1;
            core_state_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (RX_VALID) begin
                        case (rx_cmd)
                            4'h0: addr_q <= addr_shift_d;
                            4'h1: data_q <= data_shift_d;
                            4'h2, 4'h3: begin
                                state_q    <= S_BUS;
                                req_q      <= 1'b1;
                                we_q       <= rx_cmd[0];
                                inc_q      <= rx_n[0];
                                cnt_q      <= '0;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                            4'h4: begin
                                // Freeze the data register; the first nibble goes out now.
                                state_q    <= S_DUMP;
                                snap_q     <= data_q << 4;
                                rem_q      <= 4'(NNIB);
                                tx_data_q  <= {4'h5, data_q[DATA_W-1 -: 4]};
                                tx_valid_q <= 1'b1;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                            4'hB: begin
                                case (rx_n)
                                    4'h0: core_rst_q   <= 1'b0;
                                    4'h1: core_rst_q   <= 1'b1;
                                    4'h2: core_state_q <= 2'd0;
                                    4'h3: core_state_q <= 2'd1;
                                    4'h4: core_state_q <= 2'd2;
                                    default: ;
                                endcase
                            end
                            default: begin
                                state_q    <= S_RESP;
                                tx_data_q  <= ST_BADCMD;
                                tx_valid_q <= 1'b1;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b1;
                            end
                        endcase
                    end
                end

                S_BUS: begin
                    cnt_q <= cnt_q + CW'(1);
                    // An ACK on the final cycle still beats the timeout.
                    if (ICE_BUS_ACK) begin
                        req_q <= 1'b0;
                        if (!we_q) data_q <= ICE_BUS_RDATA;
                        if (inc_q) addr_q <= addr_inc_d;
                        tx_data_q  <= ST_OK;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q      <= 1'b0;
                        tx_data_q  <= ST_TIMEOUT;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (TX_READY) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end

                S_DUMP: begin
                    if (TX_READY) begin
                        if (rem_q == 4'd0) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            rem_q <= rem_q - 4'd1;
                            if (rem_q == 4'd1) begin
                                tx_data_q <= ST_OK;
                            end else begin
                                tx_data_q <= {4'h5, snap_q[DATA_W-1 -: 4]};
                                snap_q    <= snap_shift_d;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RX_READY       = rx_ready_q;
    assign TX_DATA        = tx_data_q;
    assign TX_VALID       = tx_valid_q;
    assign ICE_BUS_REQ    = req_q;
    assign ICE_BUS_WE     = we_q;
    assign ICE_BUS_ADDR   = addr_q;
    assign ICE_BUS_WDATA  = data_q;
    assign ICE_CORE_RESET = core_rst_q;
    assign ICE_CORE_STATE = core_state_q;
    assign ICE_BUSY       = busy_q;

endmodule

// File: tb/tb_ice_bridge.sv
// tb_ice_bridge: directed scenarios for ice_bridge with hand-computed expectations.
module tb_ice_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        ICE_BUS_REQ;
    logic        ICE_BUS_WE;
    logic [15:0] ICE_BUS_ADDR;
    logic [15:0] ICE_BUS_WDATA;
    logic [15:0] ICE_BUS_RDATA;
    logic        ICE_BUS_ACK;
    logic        ICE_CORE_RESET;
    logic [1:0]  ICE_CORE_STATE;
    logic        ICE_BUSY;

    int checks = 0;
    int passes = 0;
    logic [7:0] got_q[$];
    int stall_err;

    always #5 CLK = ~CLK;

    ice_bridge #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .ICE_BUS_REQ(ICE_BUS_REQ), .ICE_BUS_WE(ICE_BUS_WE),
        .ICE_BUS_ADDR(ICE_BUS_ADDR), .ICE_BUS_WDATA(ICE_BUS_WDATA),
        .ICE_BUS_RDATA(ICE_BUS_RDATA), .ICE_BUS_ACK(ICE_BUS_ACK),
        .ICE_CORE_RESET(ICE_CORE_RESET), .ICE_CORE_STATE(ICE_CORE_STATE),
        .ICE_BUSY(ICE_BUSY)
    );

    // Offer one byte at a negedge once RX_READY is up; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!RX_READY && n < 50) begin @(negedge CLK); n++; end
        if (!RX_READY) begin
            checks++;
            $display("FAIL send_ready: RX_READY=%0b required 1 (byte %h)", RX_READY, b);
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    // Drain n TX bytes into got_q; toggle=1 alternates TX_READY starting low.
    task automatic collect(input int n, input bit toggle);
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        int cyc = 0;
        got_q.delete();
        stall_err = 0;
        while (got_q.size() < n && cyc < 200) begin
            TX_READY = toggle ? cyc[0] : 1'b1;
            if (stalled && (!TX_VALID || TX_DATA !== held)) stall_err++;
            stalled = 1'b0;
            if (TX_VALID) begin
                if (TX_READY) got_q.push_back(TX_DATA);
                else begin stalled = 1'b1; held = TX_DATA; end
            end
            cyc++;
            @(negedge CLK);
        end
        TX_READY = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (ICE_BUS_ADDR !== 16'h0000) $display("FAIL rst_addr: got %h need 0000", ICE_BUS_ADDR); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'h0000) $display("FAIL rst_wdata: got %h need 0000", ICE_BUS_WDATA); else passes++;
        checks++; if (ICE_CORE_RESET !== 1'b1) $display("FAIL rst_core_reset: got %b need 1", ICE_CORE_RESET); else passes++;
        checks++; if (ICE_CORE_STATE !== 2'd0) $display("FAIL rst_core_state: got %0d need 0", ICE_CORE_STATE); else passes++;
        checks++; if (RX_READY !== 1'b1) $display("FAIL rst_rx_ready: got %b need 1", RX_READY); else passes++;
        checks++; if (TX_VALID !== 1'b0) $display("FAIL rst_tx_valid: got %b need 0", TX_VALID); else passes++;
        checks++; if (TX_DATA !== 8'h00) $display("FAIL rst_tx_data: got %h need 00", TX_DATA); else passes++;
        checks++; if (ICE_BUS_REQ !== 1'b0 || ICE_BUS_WE !== 1'b0) $display("FAIL rst_req_we: got %b%b need 00", ICE_BUS_REQ, ICE_BUS_WE); else passes++;
        checks++; if (ICE_BUSY !== 1'b0) $display("FAIL rst_busy: got %b need 0", ICE_BUSY); else passes++;
    endtask

    task automatic test_write();
        logic [7:0] cmds [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
        foreach (cmds[i]) send_byte(cmds[i]);
        checks++; if (TX_VALID !== 1'b0) $display("FAIL load_silent: TX_VALID got %b need 0", TX_VALID); else passes++;
        send_byte(8'h31);
        checks++; if (ICE_BUS_REQ !== 1'b1 || ICE_BUS_WE !== 1'b1) $display("FAIL wr_req_we: got %b%b need 11", ICE_BUS_REQ, ICE_BUS_WE); else passes++;
        checks++; if (ICE_BUS_ADDR !== 16'h1234) $display("FAIL wr_addr: got %h need 1234", ICE_BUS_ADDR); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'hABCD) $display("FAIL wr_wdata: got %h need abcd", ICE_BUS_WDATA); else passes++;
        checks++; if (ICE_BUSY !== 1'b1 || RX_READY !== 1'b0) $display("FAIL wr_busy: busy/rdy got %b%b need 10", ICE_BUSY, RX_READY); else passes++;
        @(negedge CLK);
        @(negedge CLK);
        ICE_BUS_ACK = 1'b1;
        @(negedge CLK);
        ICE_BUS_ACK = 1'b0;
        checks++; if (ICE_BUS_REQ !== 1'b0) $display("FAIL wr_req_drop: got %b need 0", ICE_BUS_REQ); else passes++;
        checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA0) $display("FAIL wr_status: got v=%b %h need v=1 a0", TX_VALID, TX_DATA); else passes++;
        checks++; if (ICE_BUS_ADDR !== 16'h1235) $display("FAIL wr_addr_inc: got %h need 1235", ICE_BUS_ADDR); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'hABCD) $display("FAIL wr_data_keep: got %h need abcd", ICE_BUS_WDATA); else passes++;
        collect(1, 1'b0);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA0) $display("FAIL wr_tx: got %0d bytes first %h need 1 byte a0", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx); else passes++;
        checks++; if (RX_READY !== 1'b1 || ICE_BUSY !== 1'b0) $display("FAIL wr_idle: rdy/busy got %b%b need 10", RX_READY, ICE_BUSY); else passes++;
    endtask

    task automatic test_read_dump();
        logic [7:0] exp [5] = '{8'h55, 8'h5A, 8'h55, 8'h5A, 8'hA0};
        logic [7:0] g;
        repeat (4) send_byte(8'h0F);
        checks++; if (ICE_BUS_ADDR !== 16'hFFFF) $display("FAIL rd_addr_load: got %h need ffff", ICE_BUS_ADDR); else passes++;
        send_byte(8'h21);
        checks++; if (ICE_BUS_REQ !== 1'b1 || ICE_BUS_WE !== 1'b0) $display("FAIL rd_req_we: got %b%b need 10", ICE_BUS_REQ, ICE_BUS_WE); else passes++;
        ICE_BUS_RDATA = 16'h5A5A;
        ICE_BUS_ACK   = 1'b1;
        @(negedge CLK);
        ICE_BUS_ACK   = 1'b0;
        checks++; if (ICE_BUS_WDATA !== 16'h5A5A) $display("FAIL rd_capture: got %h need 5a5a", ICE_BUS_WDATA); else passes++;
        checks++; if (ICE_BUS_ADDR !== 16'h0000) $display("FAIL rd_addr_wrap: got %h need 0000", ICE_BUS_ADDR); else passes++;
        collect(1, 1'b0);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA0) $display("FAIL rd_tx: got %0d bytes need 1 byte a0", got_q.size()); else passes++;
        // A stray ACK while idle must not touch the data register.
        ICE_BUS_RDATA = 16'h1234;
        ICE_BUS_ACK   = 1'b1;
        @(negedge CLK);
        ICE_BUS_ACK   = 1'b0;
        checks++; if (ICE_BUS_WDATA !== 16'h5A5A || TX_VALID !== 1'b0) $display("FAIL idle_ack: data %h v=%b need 5a5a v=0", ICE_BUS_WDATA, TX_VALID); else passes++;
        send_byte(8'h40);
        collect(5, 1'b1);
        checks++; if (got_q.size() != 5) $display("FAIL dump_count: got %0d need 5", got_q.size()); else passes++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== exp[i]) $display("FAIL dump_byte%0d: got %h need %h", i, g, exp[i]); else passes++;
        end
        checks++; if (stall_err != 0) $display("FAIL dump_stable: %0d unstable stalls need 0", stall_err); else passes++;
        checks++; if (RX_READY !== 1'b1 || ICE_BUSY !== 1'b0) $display("FAIL dump_idle: rdy/busy got %b%b need 10", RX_READY, ICE_BUSY); else passes++;
    endtask

    task automatic test_timeout();
        int n = 0;
        send_byte(8'h20);
        while (ICE_BUS_REQ === 1'b1 && n < 50) begin n++; @(negedge CLK); end
        checks++; if (n != 8) $display("FAIL to_req_cycles: got %0d need 8", n); else passes++;
        checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hE0) $display("FAIL to_status: got v=%b %h need v=1 e0", TX_VALID, TX_DATA); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'h5A5A || ICE_BUS_ADDR !== 16'h0000) $display("FAIL to_keep: data %h addr %h need 5a5a 0000", ICE_BUS_WDATA, ICE_BUS_ADDR); else passes++;
        collect(1, 1'b0);
        checks++; if (got_q.size() != 1 || got_q[0] !== 8'hE0) $display("FAIL to_tx: got %0d bytes need 1 byte e0", got_q.size()); else passes++;
        // ACK arriving on the final REQ cycle wins over the timeout.
        send_byte(8'h20);
        repeat (7) @(negedge CLK);
        checks++; if (ICE_BUS_REQ !== 1'b1) $display("FAIL to_edge_req: got %b need 1", ICE_BUS_REQ); else passes++;
        ICE_BUS_RDATA = 16'h0F0F;
        ICE_BUS_ACK   = 1'b1;
        @(negedge CLK);
        ICE_BUS_ACK   = 1'b0;
        checks++; if (ICE_BUS_REQ !== 1'b0 || TX_DATA !== 8'hA0) $display("FAIL to_edge_ack: req %b status %h need 0 a0", ICE_BUS_REQ, TX_DATA); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'h0F0F || ICE_BUS_ADDR !== 16'h0000) $display("FAIL to_edge_data: data %h addr %h need 0f0f 0000", ICE_BUS_WDATA, ICE_BUS_ADDR); else passes++;
        collect(1, 1'b0);
    endtask

    task automatic test_core_ctrl();
        send_byte(8'hB0);
        checks++; if (ICE_CORE_RESET !== 1'b0) $display("FAIL core_rst_clr: got %b need 0", ICE_CORE_RESET); else passes++;
        send_byte(8'hB3);
        checks++; if (ICE_CORE_STATE !== 2'd1) $display("FAIL core_state1: got %0d need 1", ICE_CORE_STATE); else passes++;
        send_byte(8'hB7);
        checks++; if (ICE_CORE_STATE !== 2'd1 || ICE_CORE_RESET !== 1'b0) $display("FAIL core_noop: st %0d rst %b need 1 0", ICE_CORE_STATE, ICE_CORE_RESET); else passes++;
        checks++; if (TX_VALID !== 1'b0 || RX_READY !== 1'b1) $display("FAIL core_silent: v/rdy got %b%b need 01", TX_VALID, RX_READY); else passes++;
        send_byte(8'h70);
        checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hEF) $display("FAIL badcmd: got v=%b %h need v=1 ef", TX_VALID, TX_DATA); else passes++;
    endtask

    task automatic test_back_to_back();
        // Bridge is in RESP holding 0xEF; offer a byte and stall TX.
        RX_DATA  = 8'hB4;
        RX_VALID = 1'b1;
        TX_READY = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (RX_READY !== 1'b0 || ICE_BUSY !== 1'b1) $display("FAIL bp_rdy: rdy/busy got %b%b need 01", RX_READY, ICE_BUSY); else passes++;
        checks++; if (ICE_CORE_STATE !== 2'd1) $display("FAIL bp_not_taken: got %0d need 1", ICE_CORE_STATE); else passes++;
        checks++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hEF) $display("FAIL bp_hold: got v=%b %h need v=1 ef", TX_VALID, TX_DATA); else passes++;
        TX_READY = 1'b1;
        @(negedge CLK);
        TX_READY = 1'b0;
        checks++; if (RX_READY !== 1'b1 || TX_VALID !== 1'b0) $display("FAIL bp_release: rdy/v got %b%b need 10", RX_READY, TX_VALID); else passes++;
        @(negedge CLK);
        RX_VALID = 1'b0;
        checks++; if (ICE_CORE_STATE !== 2'd2) $display("FAIL bp_taken: got %0d need 2", ICE_CORE_STATE); else passes++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic [7:0] g;
        send_byte(8'h20);
        @(negedge CLK);
        checks++; if (ICE_BUS_REQ !== 1'b1) $display("FAIL mid_req: got %b need 1", ICE_BUS_REQ); else passes++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (ICE_BUS_REQ !== 1'b0 || ICE_BUSY !== 1'b0) $display("FAIL mid_rst: req/busy got %b%b need 00", ICE_BUS_REQ, ICE_BUSY); else passes++;
        checks++; if (RX_READY !== 1'b1 || TX_VALID !== 1'b0) $display("FAIL mid_rst_io: rdy/v got %b%b need 10", RX_READY, TX_VALID); else passes++;
        checks++; if (ICE_BUS_WDATA !== 16'h0000 || ICE_CORE_RESET !== 1'b1 || ICE_CORE_STATE !== 2'd0) $display("FAIL mid_rst_regs: data %h rst %b st %0d need 0000 1 0", ICE_BUS_WDATA, ICE_CORE_RESET, ICE_CORE_STATE); else passes++;
        TX_READY = 1'b1;
        repeat (10) begin
            if (TX_VALID) seen++;
            @(negedge CLK);
        end
        TX_READY = 1'b0;
        checks++; if (seen != 0) $display("FAIL mid_no_tx: got %0d tx cycles need 0", seen); else passes++;
        send_byte(8'h40);
        collect(5, 1'b0);
        checks++; if (got_q.size() != 5) $display("FAIL mid_dump_count: got %0d need 5", got_q.size()); else passes++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            checks++; if (g !== ((i == 4) ? 8'hA0 : 8'h50)) $display("FAIL mid_dump%0d: got %h need %h", i, g, (i == 4) ? 8'hA0 : 8'h50); else passes++;
        end
    endtask

    initial begin
        RST           = 1'b1;
        RX_DATA       = 8'h00;
        RX_VALID      = 1'b0;
        TX_READY      = 1'b0;
        ICE_BUS_RDATA = 16'h0000;
        ICE_BUS_ACK   = 1'b0;
        test_reset();
        test_write();
        test_read_dump();
        test_timeout();
        test_core_ctrl();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ice_bridge.md
Name: ice_bridge

Overview:
- UART-side debug bridge, next generation of the ICE command decoder: consumes command bytes from a UART RX byte stream, drives the ICE bus and core-control outputs, and returns status and data bytes to a UART TX byte stream.
- Generalised to parametrised address/data widths, real bus read/write transactions with ACK handshake and timeout, optional address auto-increment, and a data readback command.
- Sits between the uart_rx/uart_tx pair and the core's ICE bus port.

Parameters:
- ADDR_W, 16, address register width; multiple of 4, 4..32.
- DATA_W, 16, data register width; multiple of 4, 4..32.
- TIMEOUT, 255, max cycles REQ waits for ACK before abort; 1..65535.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- RX_DATA  in  8  command byte from UART RX
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  bridge accepts a byte this cycle (RX_VALID && RX_READY)
- TX_DATA  out  8  response byte to UART TX
- TX_VALID  out  1  TX_DATA valid, held until TX_READY
- TX_READY  in  1  UART TX accepts byte
- ICE_BUS_REQ  out  1  bus transaction request
- ICE_BUS_WE  out  1  1 = write, 0 = read; valid while REQ
- ICE_BUS_ADDR  out  ADDR_W  address register, driven continuously
- ICE_BUS_WDATA  out  DATA_W  data register, driven continuously
- ICE_BUS_RDATA  in  DATA_W  read data, sampled on ACK
- ICE_BUS_ACK  in  1  transaction complete
- ICE_CORE_RESET  out  1  hold core in reset
- ICE_CORE_STATE  out  2  run-control state to core
- ICE_BUSY  out  1  FSM not in IDLE

Behaviour:
- Command byte: cmd = RX_DATA[7:4], n = RX_DATA[3:0].
- cmd 0: addr <= {addr[ADDR_W-5:0], n} (nibble shift-in, MS first). Silent.
- cmd 1: data <= {data[DATA_W-5:0], n}. Silent.
- cmd 2: bus read; cmd 3: bus write. n[0] = 1 adds addr <= addr+1 after completion, wrap mod 2^ADDR_W, applied on ACK only.
- cmd 4: dump data as DATA_W/4 bytes {4'h5, nibble}, MS nibble first, then status 0xA0.
- cmd 0xB: n=0 CORE_RESET<=0; n=1 CORE_RESET<=1; n=2/3/4 CORE_STATE<=0/1/2; n>=5 no effect. Silent.
- Any other cmd: status byte 0xEF.
- Reset values: addr 0, data 0, REQ 0, WE 0, TX_VALID 0, TX_DATA 0, ICE_CORE_RESET 1, ICE_CORE_STATE 0, RX_READY 1, ICE_BUSY 0, FSM IDLE, timeout counter 0.
- FSM states: IDLE, BUS, RESP, DUMP.
  - IDLE: RX_READY=1. Silent commands take effect the cycle after acceptance and stay in IDLE. cmd 2/3 -> BUS. cmd 4 -> DUMP. Unknown cmd -> RESP.
  - BUS: REQ=1 and WE fixed, starting the cycle after acceptance. REQ held until ACK is sampled high or the counter reaches TIMEOUT.
    - ACK: read captures RDATA into data; status 0xA0 -> RESP. REQ drops the next cycle.
    - Timeout: status 0xE0; addr/data unchanged; -> RESP. ACK in the same cycle as timeout counts as ACK.
  - RESP: TX_VALID=1 with status byte, held stable until TX_READY; the cycle after handshake -> IDLE.
  - DUMP: emits nibble bytes then 0xA0, one per TX handshake; the data snapshot is fixed at entry; -> IDLE after the status byte.
- RX_READY=0 in all states except IDLE (backpressure; no byte is dropped or queued). ICE_BUSY = (state != IDLE).
- ACK received while REQ=0 is ignored.
- RST mid-transaction: all state returns to reset values the next cycle, including REQ=0 and TX_VALID=0. The partial response is lost.
- Arithmetic: timeout counter width is ceil(log2(TIMEOUT+1)). Counter cleared on BUS entry.

Test Plan:
- Reset: hold RST 2 cycles -> ADDR 0x0000, WDATA 0x0000, CORE_RESET 1, STATE 0, RX_READY 1, TX_VALID 0.
- Bytes 0x01,0x02,0x03,0x04,0x1A,0x1B,0x1C,0x1D,0x31, ACK after 3 cycles -> REQ high with WE=1, ADDR 0x1234, WDATA 0xABCD; then status 0xA0; ADDR becomes 0x1235.
- ADDR 0xFFFF, byte 0x21, RDATA 0x5A5A with ACK -> data 0x5A5A, ADDR wraps to 0x0000. Then byte 0x40 -> TX 0x55,0x5A,0x55,0x5A,0xA0 with TX_READY toggling; bytes stable while stalled.
- TIMEOUT=8, byte 0x20, ACK never -> REQ high exactly 8 cycles, status 0xE0, data and addr unchanged; ACK on the timeout cycle -> 0xA0 instead.
- Bytes 0xB0, 0xB3 -> CORE_RESET 0, STATE 1, no TX bytes. Byte 0x70 -> TX 0xEF. RX byte offered while BUSY -> RX_READY 0, byte accepted only after return to IDLE.
- RST asserted while REQ high -> next cycle REQ 0, state IDLE, no TX byte; a subsequent 0x40 dumps 0x50,0x50,0x50,0x50,0xA0.
